// File: rtl/rf_alu_2_pkg.sv
// rf_alu_2_pkg: opcodes, ALU control bundle and opcode decode for the 2-bit ALU issuer
package rf_alu_2_pkg;
  localparam int ALU_LAT_DEFAULT = 7;
  typedef enum logic [2:0] {ADD, SUB, RSUB, AND, XOR, XNOR, ANDN, ILL} op_e;
  typedef struct packed {
    logic carry_in;
    logic end_bar;
    logic cmpl_x;
    logic cmpl_y;
    logic op_and;
    logic op_xor;
    logic op_arith;
  } alu_ctl_t;
  function automatic alu_ctl_t decode(op_e op);
    alu_ctl_t c;
    c          = '0;
    c.op_arith = op inside {ADD, SUB, RSUB};
    c.carry_in = op inside {SUB, RSUB};
    c.cmpl_x   = op inside {RSUB, XNOR};
    c.cmpl_y   = op inside {SUB, ANDN};
    c.op_and   = op inside {AND, ANDN};
    c.op_xor   = op inside {XOR, XNOR};
    return c;
  endfunction
endpackage

// File: rtl/rf_alu_2_rsp_fifo.sv
// rf_alu_2_rsp_fifo: first-word fall-through response FIFO with occupancy count
module rf_alu_2_rsp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  always_comb begin
    wr_d  = wr_q + AW'(push);
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= din;
  assign valid = cnt_q != '0;
  assign dout  = valid ? mem_q[rd_q] : '0;
  assign count = cnt_q;
  assert property (@(posedge clk) disable iff (rst) !(push && !pop && cnt_q == (AW+1)'(DEPTH)));
endmodule

// File: rtl/rf_alu_2_issuer.sv
// rf_alu_2_issuer: credit-limited issue of decoded ops into a fixed-latency ALU with in-order tagged responses
import rf_alu_2_pkg::*;
module rf_alu_2_issuer #(
  parameter int   ALU_LAT     = ALU_LAT_DEFAULT,
  parameter int   FIFO_DEPTH  = 4,
  parameter int   TAG_W       = 4,
  parameter logic END_BAR_VAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [1:0]       req_x,
  input  logic [1:0]       req_y,
  input  logic [TAG_W-1:0] req_tag,
  output logic [1:0]       alu_xin,
  output logic [1:0]       alu_yin,
  output logic             alu_carry_in,
  output logic             alu_end_bar,
  output logic             alu_cmpl_x,
  output logic             alu_cmpl_y,
  output logic             alu_op_and,
  output logic             alu_op_xor,
  output logic             alu_op_arith,
  input  logic [1:0]       alu_zout,
  input  logic             alu_carry_out,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_z,
  output logic             rsp_carry,
  output logic             rsp_ovf,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int EW = TAG_W + 2;
  alu_ctl_t                     ctl_q, ctl_d;
  logic [1:0]                   x_q, x_d, y_q, y_d;
  logic [EW-1:0]                lau_q, lau_d;
  logic [ALU_LAT-1:0][EW-1:0]   sr_q, sr_d;
  logic [CW-1:0]                cred_q, cred_d;
  logic [CW-1:0]                fifo_cnt;
  logic [4+TAG_W:0]             head;
  logic                         accept, pop, push;
  assign req_ready = ~rst & (cred_q < CW'(FIFO_DEPTH));
  assign accept    = req_valid & req_ready;
  assign pop       = rsp_valid & rsp_ready;
  assign push      = sr_q[ALU_LAT-1][EW-1];
  // lau/sr entries are {launched, err, tag}; the decode register is the launch slot, sr adds ALU_LAT more
  always_comb begin
    ctl_d         = accept ? decode(op_e'(req_op)) : '0;
    ctl_d.end_bar = accept & END_BAR_VAL;
    x_d           = accept ? req_x : '0;
    y_d           = accept ? req_y : '0;
    lau_d         = {accept, accept & (op_e'(req_op) == ILL), accept ? req_tag : '0};
    sr_d          = {sr_q[ALU_LAT-2:0], lau_q};
    cred_d        = cred_q + CW'(accept) - CW'(pop);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ctl_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      lau_q  <= '0;
      sr_q   <= '0;
      cred_q <= '0;
    end else begin
      ctl_q  <= ctl_d;
      x_q    <= x_d;
      y_q    <= y_d;
      lau_q  <= lau_d;
      sr_q   <= sr_d;
      cred_q <= cred_d;
    end
  assign {alu_carry_in, alu_end_bar, alu_cmpl_x, alu_cmpl_y, alu_op_and, alu_op_xor, alu_op_arith} = ctl_q;
  assign alu_xin = x_q;
  assign alu_yin = y_q;
  rf_alu_2_rsp_fifo #(.W(5+TAG_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({alu_zout, alu_carry_out, alu_overflow, sr_q[ALU_LAT-1][TAG_W:0]}),
    .pop   (pop),
    .dout  (head),
    .valid (rsp_valid),
    .count (fifo_cnt)
  );
  assign {rsp_z, rsp_carry, rsp_ovf, rsp_err, rsp_tag} = head;
  assert property (@(posedge clk) disable iff (rst) cred_q <= CW'(FIFO_DEPTH) && fifo_cnt <= cred_q);
endmodule
